// File: rtl/mesa_ro_arb.sv
// mesa_ro_arb -- packet-atomic round-robin arbiter for the MesaBus Ro byte path.
//
// Several readback sources (core readout, ID reporter, trigger/status reporters)
// share the single Ro byte path into the byte-to-ASCII serialiser. One source is
// granted per Ro packet. The grant is released only by that source's done pulse,
// or by a forced timeout when that feature is compiled in.
//
// Optional feature macro: MESA_RO_ARB_TIMEOUT_EN
//   defined   : a granted source that stays silent for TIMEOUT_CYC clocks is
//               forcibly released. A done is synthesised and timeout_evt pulses.
//   undefined : no idle counter; timeout_evt is tied low.
//
// Ports
//   clk              in   system clock
//   reset_n          in   asynchronous active-low reset
//   req              in   [NUM_REQ]   level request per source, held until its packet completes
//   ro_byte_d_in     in   [8*NUM_REQ] source n byte on [8n+7:8n]
//   ro_byte_en_in    in   [NUM_REQ]   source n byte strobe, 1 clk per byte
//   ro_done_in       in   [NUM_REQ]   source n end-of-packet pulse
//   grant            out  [NUM_REQ]   one-hot grant, registered
//   req_busy         out  [NUM_REQ]   granted source sees mesa_ro_busy, others see 1
//   mesa_ro_busy     in   downstream serialiser busy
//   mesa_ro_byte_d   out  arbitrated byte (holds last value between strobes)
//   mesa_ro_byte_en  out  arbitrated byte strobe
//   mesa_ro_done     out  arbitrated end-of-packet pulse
//   timeout_evt      out  1-clk pulse on forced release
//   state_dbg        out  FSM state (0 idle, 1 grant, 2 flush)
//
// Handshake: a source owns the path from the clock its grant bit is high until
// it pulses ro_done_in. It may present one byte per clock on ro_byte_en_in and
// paces itself on req_busy. The arbiter never stalls or buffers: every granted
// strobe is forwarded one clock later. Strobes from non-granted sources are
// dropped.

module mesa_ro_arb #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] ro_byte_d_in,
  input  logic [NUM_REQ-1:0]   ro_byte_en_in,
  input  logic [NUM_REQ-1:0]   ro_done_in,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   req_busy,
  input  logic                 mesa_ro_busy,
  output logic [7:0]           mesa_ro_byte_d,
  output logic                 mesa_ro_byte_en,
  output logic                 mesa_ro_done,
  output logic                 timeout_evt,
  output logic [1:0]           state_dbg
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [NUM_REQ-1:0]   grant_nxt;
  logic [IDX_W-1:0]     last_winner, last_winner_nxt;
  logic [3:0]           gap_cnt, gap_cnt_nxt;
  logic [7:0]           byte_d_nxt;
  logic                 byte_en_nxt;
  logic                 done_nxt;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;

  logic                 sel_en;
  logic                 sel_done;
  logic [7:0]           sel_byte;

`ifdef MESA_RO_ARB_TIMEOUT_EN
  logic [15:0]          to_cnt, to_cnt_nxt;
  logic                 tevt_q, tevt_nxt;
`endif

  assign state_dbg = state;

  // While in GRANT, last_winner is the index of the source that owns the path.
  assign sel_en   = ro_byte_en_in[last_winner];
  assign sel_done = ro_done_in[last_winner];
  assign sel_byte = ro_byte_d_in[{last_winner, 3'b000} +: 8];

  // Only the granted source sees the real serialiser busy. Every other source
  // is held off.
  assign req_busy = (grant & {NUM_REQ{mesa_ro_busy}}) | ~grant;

  // Round-robin search. Start one past the previous winner and wrap, so the
  // source that was just served is the last one considered.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_winner;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int cand;
      cand = int'(last_winner) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    last_winner_nxt = last_winner;
    gap_cnt_nxt     = gap_cnt;
    byte_d_nxt      = mesa_ro_byte_d;
    byte_en_nxt     = 1'b0;
    done_nxt        = 1'b0;
`ifdef MESA_RO_ARB_TIMEOUT_EN
    to_cnt_nxt      = to_cnt;
    tevt_nxt        = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (win_found) begin
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          last_winner_nxt    = win_idx;
          state_nxt          = S_GRANT;
`ifdef MESA_RO_ARB_TIMEOUT_EN
          to_cnt_nxt         = '0;
`endif
        end
      end
      S_GRANT: begin
        byte_en_nxt = sel_en;
        done_nxt    = sel_done;
        if (sel_en) byte_d_nxt = sel_byte;
`ifdef MESA_RO_ARB_TIMEOUT_EN
        to_cnt_nxt = sel_en ? 16'd0 : to_cnt + 16'd1;
`endif
        if (sel_done) begin
          // A real done always wins over a timeout in the same cycle.
          grant_nxt   = '0;
          gap_cnt_nxt = '0;
          state_nxt   = S_FLUSH;
        end
`ifdef MESA_RO_ARB_TIMEOUT_EN
        else if (!sel_en && to_cnt == 16'(TIMEOUT_CYC - 1)) begin
          // This is the TIMEOUT_CYC-th consecutive idle clock. Close the
          // packet on the source's behalf.
          done_nxt    = 1'b1;
          tevt_nxt    = 1'b1;
          grant_nxt   = '0;
          gap_cnt_nxt = '0;
          state_nxt   = S_FLUSH;
        end
`endif
      end
      S_FLUSH: begin
        if (gap_cnt == 4'(GAP_CYC - 1)) begin
          gap_cnt_nxt = '0;
          state_nxt   = S_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 4'd1;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      grant           <= '0;
      last_winner     <= IDX_W'(NUM_REQ - 1);
      gap_cnt         <= '0;
      mesa_ro_byte_d  <= 8'h00;
      mesa_ro_byte_en <= 1'b0;
      mesa_ro_done    <= 1'b0;
    end else begin
      state           <= state_nxt;
      grant           <= grant_nxt;
      last_winner     <= last_winner_nxt;
      gap_cnt         <= gap_cnt_nxt;
      mesa_ro_byte_d  <= byte_d_nxt;
      mesa_ro_byte_en <= byte_en_nxt;
      mesa_ro_done    <= done_nxt;
    end
  end

`ifdef MESA_RO_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
      tevt_q <= 1'b0;
    end else begin
      to_cnt <= to_cnt_nxt;
      tevt_q <= tevt_nxt;
    end
  end

  assign timeout_evt = tevt_q;
`else
  assign timeout_evt = 1'b0;
`endif

endmodule

// File: tb/tb_mesa_ro_arb.sv
// tb_mesa_ro_arb -- directed bench for mesa_ro_arb (NUM_REQ=4, GAP_CYC=2,
// TIMEOUT_CYC=16). Inputs change 1 ns after the rising edge, and outputs are
// sampled at that same point.

module tb_mesa_ro_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] d_in;
  logic [3:0]  en_in;
  logic [3:0]  done_in;
  logic [3:0]  grant;
  logic [3:0]  req_busy;
  logic        mesa_ro_busy;
  logic [7:0]  byte_d;
  logic        byte_en;
  logic        done;
  logic        tevt;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] rr_exp [5];
  int         rr_idx [5];

  always #5 clk = ~clk;

  mesa_ro_arb #(
    .NUM_REQ(4),
    .GAP_CYC(2),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req             (req),
    .ro_byte_d_in    (d_in),
    .ro_byte_en_in   (en_in),
    .ro_done_in      (done_in),
    .grant           (grant),
    .req_busy        (req_busy),
    .mesa_ro_busy    (mesa_ro_busy),
    .mesa_ro_byte_d  (byte_d),
    .mesa_ro_byte_en (byte_en),
    .mesa_ro_done    (done),
    .timeout_evt     (tevt),
    .state_dbg       (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n, input logic [7:0] d, input logic en, input logic dn);
    d_in[8*n +: 8] = d;
    en_in[n]       = en;
    done_in[n]     = dn;
  endtask

  task automatic clear_src();
    en_in   = '0;
    done_in = '0;
  endtask

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_idx = '{0, 1, 2, 3, 0};

    reset_n      = 1'b0;
    req          = '0;
    d_in         = '0;
    en_in        = '0;
    done_in      = '0;
    mesa_ro_busy = 1'b0;
    tick();
    tick();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_byte_d", byte_d, 8'h00);
    chk("rst_byte_en", byte_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tevt", tevt, 1'b0);
    chk("rst_state", state_dbg, 2'd0);

    // T1: grant latency, then reset in the middle of a packet
    reset_n = 1'b1;
    req     = 4'b0001;
    #1;
    chk("t1_no_comb_grant", grant, 4'b0000);
    tick();
    chk("t1_grant", grant, 4'b0001);
    drive(0, 8'h5A, 1'b1, 1'b0);
    tick();
    chk("t1_byte", byte_d, 8'h5A);
    chk("t1_byte_en", byte_en, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t1_async_grant", grant, 4'b0000);
    chk("t1_async_byte_d", byte_d, 8'h00);
    chk("t1_async_byte_en", byte_en, 1'b0);
    chk("t1_async_done", done, 1'b0);
    tick();
    chk("t1_held_byte_en", byte_en, 1'b0);
    clear_src();
    reset_n = 1'b1;
    req     = 4'b0001;
    tick();
    chk("t1_regrant", grant, 4'b0001);
    drive(0, 8'h00, 1'b0, 1'b1);
    req = 4'b0000;
    tick();
    chk("t1_done", done, 1'b1);
    chk("t1_release", grant, 4'b0000);
    clear_src();
    tick();
    tick();

    // T2: single packet from source 2
    req = 4'b0100;
    tick();
    chk("t2_grant", grant, 4'b0100);
    drive(2, 8'hF0, 1'b1, 1'b0);
    tick();
    chk("t2_b0", byte_d, 8'hF0);
    chk("t2_b0_en", byte_en, 1'b1);
    drive(2, 8'hFE, 1'b1, 1'b0);
    tick();
    chk("t2_b1", byte_d, 8'hFE);
    drive(2, 8'h00, 1'b1, 1'b0);
    tick();
    chk("t2_b2", byte_d, 8'h00);
    drive(2, 8'h10, 1'b1, 1'b0);
    tick();
    chk("t2_b3", byte_d, 8'h10);
    drive(2, 8'h10, 1'b0, 1'b1);
    req = 4'b0000;
    tick();
    chk("t2_done", done, 1'b1);
    chk("t2_done_no_en", byte_en, 1'b0);
    chk("t2_byte_hold", byte_d, 8'h10);
    chk("t2_release", grant, 4'b0000);
    clear_src();
    req = 4'b0100;
    tick();
    chk("t2_gap1", grant, 4'b0000);
    chk("t2_gap1_done", done, 1'b0);
    tick();
    chk("t2_gap2", grant, 4'b0000);
    tick();
    chk("t2_regrant", grant, 4'b0100);
    drive(2, 8'h77, 1'b1, 1'b1);
    req = 4'b0000;
    tick();
    chk("t2_same_cyc_byte", byte_d, 8'h77);
    chk("t2_same_cyc_en", byte_en, 1'b1);
    chk("t2_same_cyc_done", done, 1'b1);
    clear_src();
    tick();
    tick();

    // T3: round robin after a fresh reset (last winner = 3)
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req     = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_grant", grant, rr_exp[k]);
      for (int n = 0; n < 4; n++) drive(n, 8'(8'hA0 + n), 1'b1, 1'b0);
      done_in[rr_idx[k]] = 1'b1;
      tick();
      chk("t3_byte", byte_d, 8'(8'hA0 + rr_idx[k]));
      chk("t3_done", done, 1'b1);
      clear_src();
      tick();
      tick();
    end
    req = 4'b0000;

    // T4: non-granted source strobes while source 1 owns the path
    tick();
    req = 4'b0010;
    tick();
    chk("t4_grant", grant, 4'b0010);
    drive(3, 8'hAA, 1'b1, 1'b0);
    tick();
    chk("t4_no_strobe", byte_en, 1'b0);
    chk("t4_byte_not_aa", byte_d, 8'hA0);
    chk("t4_busy3", req_busy[3], 1'b1);
    drive(3, 8'hAA, 1'b1, 1'b1);
    drive(1, 8'h11, 1'b1, 1'b0);
    tick();
    chk("t4_own_byte", byte_d, 8'h11);
    chk("t4_foreign_done", done, 1'b0);
    chk("t4_grant_kept", grant, 4'b0010);
    clear_src();
    req = 4'b0000;
    drive(1, 8'h11, 1'b0, 1'b1);
    tick();
    chk("t4_done", done, 1'b1);
    clear_src();
    tick();
    tick();
    chk("t4_idle_busy", req_busy, 4'b1111);

    // T5: busy forwarding to the granted source only
    req = 4'b0001;
    tick();
    chk("t5_grant", grant, 4'b0001);
    mesa_ro_busy = 1'b1;
    #1;
    chk("t5_busy_hi", req_busy, 4'b1111);
    mesa_ro_busy = 1'b0;
    #1;
    chk("t5_busy_lo", req_busy, 4'b1110);
    mesa_ro_busy = 1'b1;
    #1;
    chk("t5_busy_hi2", req_busy, 4'b1111);
    mesa_ro_busy = 1'b0;
    #1;
    chk("t5_busy_lo2", req_busy, 4'b1110);
    drive(0, 8'h00, 1'b0, 1'b1);
    req = 4'b0000;
    tick();
    chk("t5_done", done, 1'b1);
    clear_src();
    tick();
    tick();

    // T6: silent source after one byte, source 1 pending
    req = 4'b0001;
    tick();
    chk("t6_grant", grant, 4'b0001);
    req = 4'b0011;
    drive(0, 8'h5C, 1'b1, 1'b0);
    tick();
    chk("t6_byte", byte_d, 8'h5C);
    clear_src();
`ifdef MESA_RO_ARB_TIMEOUT_EN
    repeat (15) tick();
    chk("t6_pre_grant", grant, 4'b0001);
    chk("t6_pre_done", done, 1'b0);
    chk("t6_pre_tevt", tevt, 1'b0);
    tick();
    chk("t6_to_done", done, 1'b1);
    chk("t6_to_en", byte_en, 1'b0);
    chk("t6_to_tevt", tevt, 1'b1);
    chk("t6_to_grant", grant, 4'b0000);
    tick();
    chk("t6_tevt_pulse", tevt, 1'b0);
    chk("t6_done_pulse", done, 1'b0);
    tick();
    chk("t6_gap", grant, 4'b0000);
    tick();
    chk("t6_next_grant", grant, 4'b0010);
    req = 4'b0000;
    drive(1, 8'h00, 1'b0, 1'b1);
    tick();
    clear_src();
    tick();
    tick();
`else
    repeat (20) tick();
    chk("t6_hold20", grant, 4'b0001);
    repeat (980) tick();
    chk("t6_hold1000", grant, 4'b0001);
    chk("t6_no_tevt", tevt, 1'b0);
    chk("t6_no_done", done, 1'b0);
    req = 4'b0010;
    drive(0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("t6_src_done", done, 1'b1);
    chk("t6_src_tevt", tevt, 1'b0);
    clear_src();
    tick();
    tick();
    tick();
    chk("t6_next_grant", grant, 4'b0010);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
